inv_key_sched: RTL and testbench
================================

# inv_key_sched

Inverse AES-128 key schedule for the decryption datapath. The block takes the final (round-10) round key, which the forward key expansion produces. It then emits round keys 10, 9, …, 0 in that order, one per valid/ready handshake, so the inverse-cipher rounds can consume them in sequence. One key is derived per cycle from the previous one, so no 11-entry key store is needed.

## Interface
Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128; sizes the round counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- start  in  1  one-cycle request; latches last_key and begins a sequence (honoured only in IDLE).
- last_key  in  128  round-10 key; word w40 = [127:96], w43 = [31:0].
- key_out  out  128  current round key, same word ordering as last_key.
- round_num  out  4  round index of key_out (10 down to 0).
- key_valid  out  1  key_out/round_num are valid.
- key_ready  in  1  consumer accepts key_out when key_valid && key_ready.
- busy  out  1  high in EMIT state.
- done  out  1  one-cycle pulse after round-0 key is accepted.

## Operation
- States: IDLE, EMIT.
- IDLE:
  - key_valid = 0, busy = 0.
  - On start: cur_key <= last_key, round <= 10, go to EMIT.
- EMIT:
  - key_valid = 1, busy = 1, key_out = cur_key, round_num = round.
  - On handshake with round > 0: cur_key <= prev(cur_key, round), round <= round - 1; stay in EMIT.
  - On handshake with round == 0: go to IDLE, done <= 1 for exactly one cycle.
- prev(k, i), with k = {a, b, c, d} (32-bit words, a = MSW):
  - d' = d ^ c, c' = c ^ b, b' = b ^ a.
  - a' = a ^ SubWord(RotWord(d')) ^ {Rcon[i], 24'h0}.
  - RotWord({x0, x1, x2, x3}) = {x1, x2, x3, x0}.
  - SubWord applies the forward AES S-box to each byte. There are 4 combinational S-box lookups, implemented in-block as a 256-entry ROM function.
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, selected by a case on round.
- While key_valid && !key_ready, key_out, round_num and key_valid hold stable. Changes to last_key have no effect after the start cycle.
- start while busy: ignored; no restart, no error.
- start in the done cycle (state is IDLE): accepted; the new sequence begins next cycle.
- key_ready while in IDLE: ignored.
- Reset (rst = 0 at posedge), including mid-sequence: state is IDLE, cur_key = 0, round = 0, and all outputs are 0. The partial sequence is abandoned, and no done is issued for it.

## Timing
- Reset values: key_out = 0, round_num = 0, key_valid = 0, busy = 0, done = 0.
- start sampled high at edge N: key_valid = 1, round_num = 10, key_out = last_key after edge N.
- Handshake at edge M: the next key is presented after edge M, giving zero-bubble throughput of one key per cycle.
- With key_ready held high, a full sequence is 11 cycles from the first key to the last handshake. done is high in the 12th cycle after N.
- The derivation path (XOR, S-box, XOR) is combinational from cur_key and is registered at the handshake. There is no additional latency.
- done is registered and lasts exactly one cycle; key_valid is 0 in that cycle.

## Test plan
- FIPS-197 A.1 vector, key_ready = 1:
  - start with last_key = d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
  - Expect round 10 = that value.
  - Expect round 9 = ac7766f3_19fadc21_28d12941_575c006e.
  - Expect round 1 = a0fafe17_88542cb1_23a33939_2a6c7605.
  - Expect round 0 = 2b7e1516_28aed2a6_abf71588_09cf4f3c.
  - done pulses once, 12 cycles after start.
- Backpressure: same vector with key_ready toggled pseudo-randomly -> key_out/round_num stay stable while stalled; the sequence and values are identical to the first test; done only after the round-0 handshake.
- Reset mid-sequence: rst = 0 while round_num = 6 -> the next cycle shows key_valid = 0 and all outputs 0. A restart then produces the full sequence from round 10.
- start while busy: pulse start with a different last_key while round_num = 7 -> sequence unaffected; round 0 = 2b7e1516_28aed2a6_abf71588_09cf4f3c.
- Back-to-back: assert start in the done cycle with last_key = 13111d7f_e3944a17_f307a78b_4d2b30c5 (round-10 key for key 000102…0f) -> round 0 = 00010203_04050607_08090a0b_0c0d0e0f with no idle gap beyond the done cycle.
- Reset state: hold rst = 0 for 3 cycles with start = 1 and key_ready = 1 -> all outputs remain 0 and no sequence starts.

Source files
------------

// File: rtl/inv_key_sched.sv
// Inverse AES-128 key schedule: walks round keys 10..0 backwards from the final
// round key, one key per valid/ready handshake.
module inv_key_sched #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic [127:0] key_out,
  output logic [3:0]   round_num,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t       state, state_next;
  logic [127:0] cur_key;
  logic [3:0]   round;
  logic         done_q, done_next;
  logic         load, step;

  logic [31:0]  wa, wb, wc, wd;
  logic [31:0]  na, nb, nc, nd;
  logic [31:0]  rot, sub;
  logic [127:0] prev_key;

  // Previous round key: undo the XOR chain first, then recover the first word
  // using the recovered last word of the previous key.
  always_comb begin
    {wa, wb, wc, wd} = cur_key;
    nd  = wd ^ wc;
    nc  = wc ^ wb;
    nb  = wb ^ wa;
    rot = {nd[23:0], nd[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    na  = wa ^ sub ^ {rcon(round), 24'h0};
    prev_key = {na, nb, nc, nd};
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (round != 4'd0) begin
            step = 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cur_key <= '0;
      round   <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
      if (load) begin
        cur_key <= last_key;
        round   <= 4'(NR);
      end else if (step) begin
        cur_key <= prev_key;
        round   <= round - 4'd1;
      end
    end
  end

  assign key_out   = cur_key;
  assign round_num = round;
  assign key_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign done      = done_q;

endmodule

// File: tb/tb_inv_key_sched.sv
// Directed bench for inv_key_sched using the FIPS-197 A.1 and 000102..0f key schedules.
module tb_inv_key_sched;

  logic         tb_clk;
  logic         rst;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] key_out;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  int unsigned pass_cnt;
  int unsigned total_cnt;
  logic [127:0] exp_a [0:10];

  localparam logic [127:0] KEY_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_X   = 128'hdeadbeef0123456789abcdeffedcba98;

  inv_key_sched #(.NR(10)) dut (
    .clk       (tb_clk),
    .rst       (rst),
    .start     (start),
    .last_key  (last_key),
    .key_out   (key_out),
    .round_num (round_num),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; key_ready = 1'b1; last_key = exp_a[10];
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({key_out, round_num, key_valid, busy, done} !== '0)
        $display("FAIL reset_outputs cyc%0d: key_out=%h round=%0d valid=%b busy=%b done=%b, want all 0",
                 i, key_out, round_num, key_valid, busy, done);
      else pass_cnt++;
    end
    rst = 1'b1; start = 1'b0;
    tick();
    total_cnt++;
    if (key_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_no_start: valid=%b busy=%b, want 0 0", key_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_fips_vector(input string tag);
    key_ready = 1'b1; last_key = exp_a[10]; start = 1'b1;
    tick();
    start = 1'b0; last_key = KEY_X;
    for (int r = 10; r >= 0; r--) begin
      total_cnt++;
      if (key_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || round_num !== 4'(r))
        $display("FAIL %s_ctrl r%0d: valid=%b busy=%b done=%b round=%0d, want 1 1 0 %0d",
                 tag, r, key_valid, busy, done, round_num, r);
      else pass_cnt++;
      total_cnt++;
      if (key_out !== exp_a[r])
        $display("FAIL %s_key r%0d: got %h want %h", tag, r, key_out, exp_a[r]);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_done: done=%b valid=%b busy=%b, want 1 0 0", tag, done, key_valid, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0)
      $display("FAIL %s_done_width: done=%b, want 0", tag, done);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int r;
    int unsigned cyc;
    last_key = exp_a[10]; start = 1'b1; key_ready = 1'b0;
    tick();
    start = 1'b0;
    r = 10; cyc = 0;
    while (r >= 0 && cyc < 200) begin
      total_cnt++;
      if (key_valid !== 1'b1 || round_num !== 4'(r) || key_out !== exp_a[r] || done !== 1'b0)
        $display("FAIL bp_hold r%0d: valid=%b round=%0d key=%h done=%b, want 1 %0d %h 0",
                 r, key_valid, round_num, key_out, done, r, exp_a[r]);
      else pass_cnt++;
      key_ready = (cyc % 5 == 4) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      if (key_ready) r--;
      cyc++;
    end
    total_cnt++;
    if (r >= 0)
      $display("FAIL bp_timeout: round index %0d still pending, want all accepted", r);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1 || key_valid !== 1'b0)
      $display("FAIL bp_done: done=%b valid=%b, want 1 0", done, key_valid);
    else pass_cnt++;
    key_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    last_key = exp_a[10]; start = 1'b1; key_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total_cnt++;
    if (round_num !== 4'd6 || key_out !== exp_a[6])
      $display("FAIL mid_pre: round=%0d key=%h, want 6 %h", round_num, key_out, exp_a[6]);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total_cnt++;
    if ({key_out, round_num, key_valid, busy, done} !== '0)
      $display("FAIL mid_reset: key_out=%h round=%0d valid=%b busy=%b done=%b, want all 0",
               key_out, round_num, key_valid, busy, done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0 || key_valid !== 1'b0)
      $display("FAIL mid_no_done: done=%b valid=%b, want 0 0", done, key_valid);
    else pass_cnt++;
    test_fips_vector("restart");
  endtask

  task automatic test_start_busy();
    last_key = exp_a[10]; start = 1'b1; key_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total_cnt++;
    if (round_num !== 4'd7)
      $display("FAIL busy_pre: round=%0d, want 7", round_num);
    else pass_cnt++;
    start = 1'b1; last_key = KEY_X;
    tick();
    start = 1'b0;
    for (int r = 6; r >= 0; r--) begin
      total_cnt++;
      if (round_num !== 4'(r) || key_out !== exp_a[r] || key_valid !== 1'b1)
        $display("FAIL busy_seq r%0d: round=%0d key=%h valid=%b, want %0d %h 1",
                 r, round_num, key_out, key_valid, r, exp_a[r]);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done !== 1'b1)
      $display("FAIL busy_done: done=%b, want 1", done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    last_key = exp_a[10]; start = 1'b1; key_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    total_cnt++;
    if (done !== 1'b1 || key_valid !== 1'b0)
      $display("FAIL b2b_done1: done=%b valid=%b, want 1 0", done, key_valid);
    else pass_cnt++;
    start = 1'b1; last_key = KEY_B10;
    tick();
    start = 1'b0;
    total_cnt++;
    if (key_valid !== 1'b1 || round_num !== 4'd10 || key_out !== KEY_B10 || done !== 1'b0)
      $display("FAIL b2b_first: valid=%b round=%0d key=%h done=%b, want 1 10 %h 0",
               key_valid, round_num, key_out, done, KEY_B10);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) tick();
    total_cnt++;
    if (round_num !== 4'd0 || key_out !== KEY_B0 || key_valid !== 1'b1)
      $display("FAIL b2b_round0: round=%0d key=%h valid=%b, want 0 %h 1",
               round_num, key_out, key_valid, KEY_B0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1)
      $display("FAIL b2b_done2: done=%b, want 1", done);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    exp_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rst = 1'b0; start = 1'b0; key_ready = 1'b0; last_key = '0;
    test_reset();
    test_fips_vector("fips");
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
